// File: rtl/td4x_core.sv
`default_nettype none
// ============================================================================
// Module   : td4x_core
// Summary  : Parametrised TD4-style execution core with a request/acknowledge
//            fetch FSM, run/step/halt control and ADD A,B.
// Revision : 1.0 - initial release
// ============================================================================
module td4x_core #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic              resume,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [3:0]        imem_opcode,
  input  logic [DATA_W-1:0] imem_imm,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [PC_W-1:0]   pc,
  output logic              carry,
  output logic              halted
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_fetch = 2'd1;
  localparam logic [1:0] c_st_exec  = 2'd2;
  localparam logic [1:0] c_st_halt  = 2'd3;

  localparam logic [3:0] c_op_add_ai = 4'b0000;
  localparam logic [3:0] c_op_add_ab = 4'b0001;
  localparam logic [3:0] c_op_in_a   = 4'b0010;
  localparam logic [3:0] c_op_mov_ab = 4'b0011;
  localparam logic [3:0] c_op_mov_ba = 4'b0100;
  localparam logic [3:0] c_op_add_bi = 4'b0101;
  localparam logic [3:0] c_op_in_b   = 4'b0110;
  localparam logic [3:0] c_op_mov_ai = 4'b0111;
  localparam logic [3:0] c_op_out_b  = 4'b1001;
  localparam logic [3:0] c_op_mov_bi = 4'b1011;
  localparam logic [3:0] c_op_halt   = 4'b1100;
  localparam logic [3:0] c_op_out_i  = 4'b1101;
  localparam logic [3:0] c_op_jnc    = 4'b1110;
  localparam logic [3:0] c_op_jmp    = 4'b1111;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [3:0]        r_ir_op;
  logic [DATA_W-1:0] r_ir_imm;
  logic [DATA_W-1:0] r_a, r_b, r_out;
  logic [PC_W-1:0]   r_pc;
  logic              r_carry;
  logic              w_req, w_halted, w_exec, w_ir_load;
  logic [DATA_W-1:0] w_a_nxt, w_b_nxt, w_out_nxt;
  logic [PC_W-1:0]   w_pc_nxt;
  logic              w_carry_nxt;
  logic [DATA_W:0]   w_sum_ai, w_sum_ab, w_sum_bi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_next_state;
  end

  // step is only looked at in IDLE, so pulses elsewhere are dropped, not queued
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (run || step) w_next_state = c_st_fetch;
      c_st_fetch: if (imem_ack) w_next_state = c_st_exec;
      c_st_exec: begin
        if (r_ir_op == c_op_halt) w_next_state = c_st_halt;
        else if (run)             w_next_state = c_st_fetch;
        else                      w_next_state = c_st_idle;
      end
      c_st_halt:  if (resume) w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    w_req     = (r_state == c_st_fetch);
    w_halted  = (r_state == c_st_halt);
    w_exec    = (r_state == c_st_exec);
    w_ir_load = w_req && imem_ack;
  end

  assign w_sum_ai = {1'b0, r_a} + {1'b0, r_ir_imm};
  assign w_sum_ab = {1'b0, r_a} + {1'b0, r_b};
  assign w_sum_bi = {1'b0, r_b} + {1'b0, r_ir_imm};

  // Carry defaults to clear: only the three ADD forms can set it
  always_comb begin
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_out_nxt   = r_out;
    w_carry_nxt = 1'b0;
    w_pc_nxt    = r_pc + PC_W'(1);
    case (r_ir_op)
      c_op_add_ai: {w_carry_nxt, w_a_nxt} = w_sum_ai;
      c_op_add_ab: {w_carry_nxt, w_a_nxt} = w_sum_ab;
      c_op_add_bi: {w_carry_nxt, w_b_nxt} = w_sum_bi;
      c_op_mov_ab: w_a_nxt   = r_b;
      c_op_mov_ba: w_b_nxt   = r_a;
      c_op_in_a:   w_a_nxt   = io_in;
      c_op_in_b:   w_b_nxt   = io_in;
      c_op_mov_ai: w_a_nxt   = r_ir_imm;
      c_op_mov_bi: w_b_nxt   = r_ir_imm;
      c_op_out_b:  w_out_nxt = r_b;
      c_op_out_i:  w_out_nxt = r_ir_imm;
      c_op_jmp:    w_pc_nxt  = r_ir_imm[PC_W-1:0];
      c_op_jnc:    if (!r_carry) w_pc_nxt = r_ir_imm[PC_W-1:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir_op  <= '0;
      r_ir_imm <= '0;
    end else if (w_ir_load) begin
      r_ir_op  <= imem_opcode;
      r_ir_imm <= imem_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_pc    <= '0;
      r_carry <= 1'b0;
    end else if (w_exec) begin
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_out   <= w_out_nxt;
      r_pc    <= w_pc_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign io_out    = r_out;
  assign reg_a     = r_a;
  assign reg_b     = r_b;
  assign pc        = r_pc;
  assign carry     = r_carry;
  assign halted    = w_halted;

endmodule
`default_nettype wire

// File: doc/td4x_core.md
Name: td4x_core

Overview:
- Parametrised successor of the 4-bit TD4-style execution core.
- Generalises data and PC width, adds a fetch FSM with a request/acknowledge instruction-memory handshake, run/single-step/halt control and an ADD A,B instruction.
- Fixes carry and branch semantics: carry is deterministic from reset, and a not-taken JNC advances the PC.
- Sits between the top-level I/O wrapper and an external instruction memory (ROM or switch bank).

Parameters:
- DATA_W, 4, width of registers A, B, OUT, immediate and io_in (>=4).
- PC_W, 4, width of program counter / imem address (1..DATA_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- run  input  1  level; 1 = free-running execution.
- step  input  1  one-cycle pulse; executes exactly one instruction while run=0.
- resume  input  1  one-cycle pulse; leaves HALT state.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_W  fetch address (= pc).
- imem_ack  input  1  memory returns instruction this cycle.
- imem_opcode  input  4  opcode, valid with imem_ack.
- imem_imm  input  DATA_W  immediate, valid with imem_ack.
- io_in  input  DATA_W  input port.
- io_out  output  DATA_W  output register.
- reg_a  output  DATA_W  register A.
- reg_b  output  DATA_W  register B.
- pc  output  PC_W  program counter.
- carry  output  1  carry flag.
- halted  output  1  1 while in HALT state.

Behaviour:
- Reset (async, rst_n=0): A, B, OUT, pc, carry, IR = 0; state IDLE; imem_req=0; halted=0. imem_req drops immediately, even mid-fetch.
- FSM states: IDLE, FETCH, EXEC, HALT.
  - IDLE -> FETCH when run=1 or step=1; step is sampled only in IDLE.
  - FETCH: imem_req=1, imem_addr=pc held stable until imem_ack. On ack, latch {opcode, imm} into IR -> EXEC.
  - EXEC (one cycle): update registers per IR. Next state is HALT if opcode=HALT; else FETCH if run=1; else IDLE.
  - HALT: no requests; halted=1. resume -> IDLE; run/step ignored.
- Deasserting run during FETCH: the fetch completes, the instruction executes, then IDLE.
- Throughput: minimum 2 cycles/instruction (ack in the same cycle as req).
- Opcode map, applied in EXEC:
  - 0000 ADD A,Im: {carry,A} <= A+imm.
  - 0001 ADD A,B: {carry,A} <= A+B.
  - 0101 ADD B,Im: {carry,B} <= B+imm.
  - 0011 MOV A,B.
  - 0100 MOV B,A.
  - 0010 IN A.
  - 0110 IN B.
  - 0111 MOV A,Im.
  - 1011 MOV B,Im.
  - 1001 OUT B.
  - 1101 OUT Im.
  - 1111 JMP Im.
  - 1110 JNC Im.
  - 1100 HALT.
  - all other opcodes: NOP.
- Arithmetic: DATA_W-bit unsigned add; carry = bit DATA_W of the sum; result wraps modulo 2^DATA_W.
- Carry: every executed non-ADD instruction, including NOP, JMP, JNC and HALT, clears carry to 0. JNC tests carry as it was before the JNC executes.
- PC:
  - JMP, and JNC with carry=0: pc <= imm[PC_W-1:0].
  - Every other instruction, including JNC not taken and HALT: pc <= pc+1, wrapping modulo 2^PC_W.
- io_in is sampled in the EXEC cycle only.
- io_out changes only on OUT instructions.
- A step pulse while not in IDLE is ignored; it is not queued.
- imem_opcode and imem_imm are ignored when imem_ack=0. An ack outside FETCH is ignored.

Test Plan (DATA_W=4, PC_W=4 unless stated):
- Reset: assert rst_n=0 mid-FETCH -> imem_req=0 the same cycle; A=B=OUT=pc=carry=0, halted=0.
- Carry: MOV A,Im 0xE; ADD A,Im 3 -> A=0x1, carry=1; then MOV B,Im 5 -> B=5, carry=0.
- JNC:
  - carry=1, JNC 0 at pc=4 -> not taken, pc=5.
  - carry=0, JNC 9 -> taken, pc=9.
  - JMP 0xF followed by a NOP -> pc wraps to 0.
- Handshake: hold imem_ack low 3 cycles after req -> imem_req=1 and imem_addr stable throughout, A/B/pc unchanged; ack on cycle 4 -> exactly one instruction executes.
- Control:
  - run=0: step pulse -> exactly one instruction executes, then IDLE.
  - HALT at pc=7 -> halted=1, pc=8, no further imem_req despite run=1.
  - resume with run=1 -> fetch resumes at address 8.
- Width: DATA_W=8, PC_W=6: MOV A,Im 0xF0; ADD A,Im 0x20 -> A=0x10, carry=1; OUT Im 0xA5 -> io_out=0xA5; JMP 0xFF -> pc=0x3F.
